// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// ----------------------------------------------------------------------------
// Initiator-side data-memory access unit. It takes one byte, halfword or word
// load/store at a time and drives a word-addressed memory that has a
// level-sensitive read enable and a rising-edge write strobe. Sub-word stores
// are done as read-modify-write; loads return zero- or sign-extended data
// together with a one-cycle done pulse.
//
// Optional feature (compile-time macro):
//   LSU_ALIGN_CHECK_EN  when defined, illegal sizes and misaligned halfword or
//                       word requests complete at once with err=1 and do not
//                       touch memory. When undefined, err is tied low,
//                       misaligned low address bits are ignored and size=11
//                       is treated as a word access.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   req           in   request valid, accepted only while ready=1
//   ready         out  unit idle, can accept req
//   we            in   1 = store, 0 = load
//   size[1:0]     in   00 byte, 01 halfword, 10 word, 11 illegal
//   signedLoad    in   1 = sign-extend a sub-word load
//   addr[31:0]    in   byte address
//   wdata[31:0]   in   store data, right-aligned for sub-word stores
//   rdata[31:0]   out  load result, valid while done=1
//   done          out  one-cycle completion pulse
//   err           out  misaligned/illegal flag, valid while done=1
//   memAddress    out  word-aligned memory address {addr[31:2],2'b00}
//   memWriteData  out  full word written to memory
//   memReadData   in   memory read word (combinational)
//   memRead       out  memory read enable
//   memWrite      out  memory write strobe, memory writes on its rising edge
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signedLoad,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic        memRead,
    output logic        memWrite
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSET,
        S_WPULSE,
        S_DONE,
        S_ERR
    } state_e;

    // ------------------------------------------------------------------------
    // Lane helpers. Byte lane k sits at bits [8k+7:8k]; halfword lane h at
    // bits [16h+15:16h], so a halfword only looks at lane[1].
    // ------------------------------------------------------------------------
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [15:0] data,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        case (sz)
            SZ_BYTE: res[{lane, 3'b000} +: 8]        = data[7:0];
            SZ_HALF: res[{lane[1], 4'b0000} +: 16]   = data;
            default: res                              = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Request decode (only meaningful while idle)
    // ------------------------------------------------------------------------
    logic [1:0] eff_size;
    logic       req_bad;

    // An illegal size behaves as a word when alignment checking is off; with
    // checking on it never reaches the access path.
    assign eff_size = (size == SZ_ILL) ? SZ_WORD : size;

`ifdef LSU_ALIGN_CHECK_EN
    assign req_bad = (size == SZ_ILL)
                   | ((size == SZ_HALF) & addr[0])
                   | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
`else
    assign req_bad = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------------
    state_e      state_q,     state_d;
    logic        we_q,        we_d;
    logic [1:0]  size_q,      size_d;
    logic        signed_q,    signed_d;
    logic [1:0]  lane_q,      lane_d;
    logic [15:0] wdata_q,     wdata_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q,     rdata_d;

    // NOTE: every register updates with <= so all flops sample the values
    // from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d     = we;
                    size_d   = eff_size;
                    signed_d = signedLoad;
                    lane_d   = addr[1:0];
                    wdata_d  = wdata[15:0];
                    // Cleared here so stores and rejected requests report 0.
                    rdata_d  = '0;
                    if (req_bad) begin
                        // memAddress/memWriteData stay put: memory is not
                        // addressed for a rejected request.
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (we && (eff_size == SZ_WORD)) begin
                            mem_wdata_d = wdata;
                            state_d     = S_WSET;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end

            S_RD: begin
                if (we_q) begin
                    // Read-modify-write: only the target lane is replaced.
                    mem_wdata_d = merge_lane(memReadData, wdata_q, size_q, lane_q);
                    state_d     = S_WSET;
                end else begin
                    rdata_d = extract_lane(memReadData, size_q, lane_q, signed_q);
                    state_d = S_DONE;
                end
            end

            // Address and data settle for a full cycle before the strobe so
            // the memory never sees them change on a memWrite rising edge.
            S_WSET:   state_d = S_WPULSE;
            S_WPULSE: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded straight from registers, so strobes drop as soon as
    // reset is asserted.
    // ------------------------------------------------------------------------
    assign ready        = (state_q == S_IDLE);
    assign memRead      = (state_q == S_RD);
    assign memWrite     = (state_q == S_WPULSE);
    assign done         = (state_q == S_DONE) || (state_q == S_ERR);
    assign rdata        = rdata_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;

`ifdef LSU_ALIGN_CHECK_EN
    assign err = (state_q == S_ERR);
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit
// ----------------------------------------------------------------------------
// Bench for load_store_unit. A word-wide memory sits on the memory port; a
// byte-array reference model predicts load results, memory contents, latency
// and strobe counts for each request.
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic        signedLoad;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memRead;
    logic        memWrite;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .ready        (ready),
        .we           (we),
        .size         (size),
        .signedLoad   (signedLoad),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .done         (done),
        .err          (err),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .memRead      (memRead),
        .memWrite     (memWrite)
    );

    // ------------------------------------------------------------------------
    // Data memory: 64 words, combinational read, write on memWrite rising edge.
    // A poke strobe lets the bench preload words.
    // ------------------------------------------------------------------------
    logic [31:0] tb_mem [0:63];
    logic        poke_stb = 1'b0;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    always @(posedge memWrite or posedge poke_stb) begin
        if (poke_stb) tb_mem[poke_idx] <= poke_val;
        else          tb_mem[memAddress[7:2]] <= memWriteData;
    end

    assign memReadData = tb_mem[memAddress[7:2]];

    // Reference model: plain byte-addressed memory, little-endian.
    logic [7:0] ref_mem [0:255];

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_idx = idx[5:0];
        poke_val = val;
        poke_stb = 1'b1;
        #1;
        poke_stb = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) ref_mem[4*idx+i] = val[8*i +: 8];
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"},        ready,        32'd1);
        check({tag, ".done"},         done,         32'd0);
        check({tag, ".err"},          err,          32'd0);
        check({tag, ".rdata"},        rdata,        32'd0);
        check({tag, ".memRead"},      memRead,      32'd0);
        check({tag, ".memWrite"},     memWrite,     32'd0);
        check({tag, ".memAddress"},   memAddress,   32'd0);
        check({tag, ".memWriteData"}, memWriteData, 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // One request, called at a falling edge. mode: 0 = req dropped after
    // accept, 1 = random req/field noise while busy, 2 = req held high.
    // ------------------------------------------------------------------------
    task automatic run_op(input string tag, input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] d,
                          input int mode, output logic [31:0] rdata_o,
                          output logic err_o, output int waited_o);
        int          n, exp_lat, exp_rd, exp_wr, lat, rd_n, wr_n, waited;
        logic        bad, got_done, both, addr_bad;
        logic [7:0]  base;
        logic [31:0] exp_r;

        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        waited_o = waited;
        check({tag, ".ready"}, ready, 32'd1);

        // Expected behaviour from the access rules.
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        bad = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
        base  = a[7:0] & ~8'(n - 1);
        exp_r = '0;
        if (!bad && !w) begin
            for (int i = 0; i < n; i++) exp_r |= 32'(ref_mem[base + i]) << (8 * i);
            if (sg && n < 4 && exp_r[8*n-1]) exp_r |= ~((32'd1 << (8 * n)) - 1);
        end
        exp_lat = bad ? 1 : !w ? 2 : (n == 4) ? 3 : 4;
        exp_rd  = (bad || (w && n == 4)) ? 0 : 1;
        exp_wr  = (!bad && w) ? 1 : 0;

        req = 1'b1; we = w; size = sz; signedLoad = sg; addr = a; wdata = d;
        @(posedge clk);

        lat = 0; rd_n = 0; wr_n = 0; got_done = 0; both = 0; addr_bad = 0;
        rdata_o = 'x; err_o = 1'bx;
        while (!got_done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (memRead)  rd_n++;
            if (memWrite) wr_n++;
            if (memRead && memWrite) both = 1;
            if ((memRead || memWrite) && memAddress !== {a[31:2], 2'b00}) addr_bad = 1;
            if (done) begin
                got_done = 1;
                rdata_o  = rdata;
                err_o    = err;
                if (mode != 2) req = 1'b0;
            end else if (mode == 1) begin
                req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
                signedLoad = 1'($urandom); addr = $urandom; wdata = $urandom;
            end else if (mode == 0) begin
                req = 1'b0;
            end
        end

        if (!bad && w) for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];

        check({tag, ".done_seen"}, got_done, 32'd1);
        check({tag, ".latency"},   lat,      exp_lat);
        check({tag, ".reads"},     rd_n,     exp_rd);
        check({tag, ".writes"},    wr_n,     exp_wr);
        check({tag, ".rd_wr_overlap"}, both, 32'd0);
        check({tag, ".mem_addr"},  addr_bad, 32'd0);
        check({tag, ".err"},       err_o,    32'(bad));
        if (!w || bad) check({tag, ".rdata"}, rdata_o, exp_r);
        check({tag, ".mem_word"}, tb_mem[a[7:2]], ref_word(int'(a[7:2])));
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence followed by randomized traffic
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] r;
        logic        e;
        int          wt;
        logic        any_done;

        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; signedLoad = 1'b0;
        addr = '0; wdata = '0;
        #1;
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(0, 32'h8000F0A5);
        poke(1, 32'h11223344);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        run_op("lb_signed", 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 0, r, e, wt);
        check("lb_signed.const", r, 32'hFFFFFFA5);
        run_op("lh_unsigned", 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 0, r, e, wt);
        check("lh_unsigned.const", r, 32'h00008000);
        run_op("sb_merge", 1'b1, 2'b00, 1'b0, 32'h5, 32'h0000003C, 0, r, e, wt);
        check("sb_merge.const", tb_mem[1], 32'h11223C44);
        run_op("sw_direct", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 0, r, e, wt);
        run_op("lw_back", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 0, r, e, wt);
        check("lw_back.const", r, 32'hDEADBEEF);
        run_op("lh_misaligned", 1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 0, r, e, wt);
`ifdef LSU_ALIGN_CHECK_EN
        check("lh_misaligned.err_const", e, 32'd1);
`else
        check("lh_misaligned.rdata_const", r, 32'h00008000);
`endif

        // Reset during WSET: the word store must never reach memory.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; signedLoad = 1'b0;
        addr = 32'hC; wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rst_wset.no_strobe_yet", memWrite, 32'd0);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_wset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("rst_wset.no_done", any_done, 32'd0);
        check("rst_wset.mem_word3", tb_mem[3], ref_word(3));
        check("rst_wset.ready", ready, 32'd1);

        // Reset during WPULSE: the write has committed, the strobe drops at once.
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_wpulse.strobe_high", memWrite, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_wpulse.strobe_async_low", memWrite, 32'd0);
        for (int i = 0; i < 4; i++) ref_mem[16 + i] = wdata[8*i +: 8];
        check("rst_wpulse.mem_word4", tb_mem[4], ref_word(4));
        @(negedge clk);
        reset = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("rst_wpulse.no_done", any_done, 32'd0);

        // Back-to-back with req held high: next request goes in the cycle
        // after done.
        run_op("b2b_store", 1'b1, 2'b10, 1'b0, 32'h0000_0024, 32'h5A5AC3C3, 2, r, e, wt);
        run_op("b2b_load", 1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0, 0, r, e, wt);
        check("b2b_load.wait_cycles", wt, 32'd1);
        check("b2b_load.const", r, 32'h5A5AC3C3);

        // Randomized traffic with busy-cycle noise on the request inputs.
        for (int k = 0; k < 150; k++) begin
            run_op($sformatf("rand%0d", k), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, $urandom, 1, r, e, wt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
